// File: rtl/shared_pin_scheduler.sv
// shared_pin_scheduler: time-shares one pulled-up bidirectional pad between
// NUM_REQ requesters. Each transaction drives the pad for a programmed number
// of cycles, releases it for a turnaround gap, then samples the synchronized
// pad level and hands it back to the requester.
module shared_pin_scheduler #(
  parameter int NUM_REQ     = 2,
  parameter int DUR_W       = 20,
  parameter int TURNAROUND  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0]       req_val,
  input  logic [NUM_REQ*DUR_W-1:0] req_dur,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       done,
  output logic                     sample_val,
  output logic                     busy,
  inout  wire                      pin
);

  localparam int IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TURN_EFF = (TURNAROUND < 1) ? 1 : TURNAROUND;
  localparam int TURN_W   = $clog2(TURN_EFF + 1);
  // One down-counter serves both the drive and turnaround phases.
  localparam int CNT_W    = (DUR_W > TURN_W) ? DUR_W : TURN_W;

  typedef enum logic [1:0] {IDLE, DRIVE, TURN, SAMPLE} state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       win_q, win_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic                   val_q, val_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_REQ-1:0]     gnt_q, gnt_d;
  logic [NUM_REQ-1:0]     done_q, done_d;
  logic                   sample_q, sample_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;

  logic                   rr_hit;
  logic [IDX_W-1:0]       rr_idx;
  logic [DUR_W-1:0]       dur_sel;
  logic                   pin_oe;
  logic                   pin_sync;

  // Pad is only ever driven in DRIVE; reset forces IDLE so release is async.
  assign pin_oe     = (state_q == DRIVE);
  assign pin        = pin_oe ? val_q : 1'bz;
  assign pin_sync   = sync_q[SYNC_STAGES-1];
  assign gnt        = gnt_q;
  assign done       = done_q;
  assign sample_val = sample_q;
  assign busy       = (state_q != IDLE);

  // Synchronizer shift: pad is read every cycle, including while we drive it.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pin};
  end

  // Round-robin pick: lowest set bit above last_q, else lowest set bit overall.
  always_comb begin
    rr_hit  = 1'b0;
    rr_idx  = '0;
    dur_sel = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[k] && (IDX_W'(k) > last_q)) begin
        rr_hit = 1'b1;
        rr_idx = IDX_W'(k);
      end
    end
    if (!rr_hit) begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        if (req[k]) begin
          rr_hit = 1'b1;
          rr_idx = IDX_W'(k);
        end
      end
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (rr_idx == IDX_W'(k)) dur_sel = req_dur[k*DUR_W +: DUR_W];
    end
  end

  // Next-state and registered-output logic for the drive/turn/sample sequence.
  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    last_d   = last_q;
    val_d    = val_q;
    cnt_d    = cnt_q;
    gnt_d    = '0;
    done_d   = '0;
    sample_d = sample_q;
    case (state_q)
      IDLE: begin
        if (rr_hit) begin
          state_d        = DRIVE;
          win_d          = rr_idx;
          val_d          = req_val[rr_idx];
          // A zero duration still drives for one cycle.
          cnt_d          = (dur_sel == '0) ? CNT_W'(1) : CNT_W'(dur_sel);
          gnt_d[rr_idx]  = 1'b1;
        end
      end
      DRIVE: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = TURN;
          cnt_d   = CNT_W'(TURN_EFF);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      TURN: begin
        if (cnt_q == CNT_W'(1)) begin
          // Capture on entry to SAMPLE so done and sample_val appear together.
          state_d       = SAMPLE;
          done_d[win_q] = 1'b1;
          sample_d      = pin_sync;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      SAMPLE: begin
        state_d = IDLE;
        last_d  = win_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset points last_q at the top index so req[0] wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      win_q    <= '0;
      last_q   <= IDX_W'(NUM_REQ - 1);
      val_q    <= 1'b0;
      cnt_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      sample_q <= 1'b0;
      sync_q   <= '0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      last_q   <= last_d;
      val_q    <= val_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      sample_q <= sample_d;
      sync_q   <= sync_d;
    end
  end

endmodule

// File: tb/tb_shared_pin_scheduler.sv
// Self-checking bench for shared_pin_scheduler: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_shared_pin_scheduler;
  localparam int NR = 2;
  localparam int DW = 20;
  localparam int T  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req, req_val, gnt, done;
  logic [NR*DW-1:0]  req_dur;
  logic              sample_val, busy;
  logic              tb_oe, tb_val;
  wire               pin;

  logic [NR-1:0]     r4_req, r4_val, r4_gnt, r4_done;
  logic [NR*4-1:0]   r4_dur;
  logic              r4_sv, r4_busy;
  wire               pin4;

  int errors = 0;
  int checks = 0;

  assign pin = tb_oe ? tb_val : 1'bz;
  pullup (pin);
  pullup (pin4);

  always #5 clk = ~clk;

  shared_pin_scheduler #(.NUM_REQ(NR), .DUR_W(DW), .TURNAROUND(T), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_val(req_val), .req_dur(req_dur),
    .gnt(gnt), .done(done), .sample_val(sample_val), .busy(busy), .pin(pin));

  shared_pin_scheduler #(.NUM_REQ(NR), .DUR_W(4), .TURNAROUND(T), .SYNC_STAGES(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .req(r4_req), .req_val(r4_val), .req_dur(r4_dur),
    .gnt(r4_gnt), .done(r4_done), .sample_val(r4_sv), .busy(r4_busy), .pin(pin4));

  task automatic test_reset();
    rst_n = 1'b0; req = '0; req_val = '0; req_dur = '0; tb_oe = 1'b0; tb_val = 1'b0;
    r4_req = '0; r4_val = '0; r4_dur = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (gnt !== '0) begin errors++; $display("FAIL rst_gnt got=%b exp=00", gnt); end
    checks++; if (done !== '0) begin errors++; $display("FAIL rst_done got=%b exp=00", done); end
    checks++; if (sample_val !== 1'b0) begin errors++; $display("FAIL rst_sample got=%b exp=0", sample_val); end
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #2;
      checks++; if (busy !== 1'b0 || gnt !== '0 || done !== '0)
        begin errors++; $display("FAIL idle_outs cyc=%0d busy=%b gnt=%b done=%b exp=0/00/00", i, busy, gnt, done); end
      checks++; if (dut.pin_oe !== 1'b0 || pin !== 1'b1)
        begin errors++; $display("FAIL idle_pin cyc=%0d oe=%b pin=%b exp oe=0 pin=1", i, dut.pin_oe, pin); end
    end
  endtask

  // One isolated transaction; optional external drive of the pad during TURN.
  task automatic test_single(input int w, input logic v, input int dur,
                             input bit ext_en, input logic ext_v, input string nm);
    int D;
    logic [NR-1:0] eg, ed;
    logic eoe, eb, ep;
    D = (dur == 0) ? 1 : dur;
    @(posedge clk); #1;
    req[w] = 1'b1; req_val[w] = v; req_dur[w*DW +: DW] = DW'(dur);
    for (int t = 1; t <= D + T + 2; t++) begin
      @(posedge clk); #1;
      tb_oe = ext_en && (t > D) && (t <= D + T); tb_val = ext_v;
      #1;
      eg  = (t == 1) ? (NR'(1) << w) : '0;
      ed  = (t == D + T + 1) ? (NR'(1) << w) : '0;
      eoe = (t <= D);
      eb  = (t <= D + T + 1);
      ep  = eoe ? v : (tb_oe ? ext_v : 1'b1);
      checks++; if (gnt !== eg) begin errors++; $display("FAIL %s_gnt t=%0d got=%b exp=%b", nm, t, gnt, eg); end
      checks++; if (done !== ed) begin errors++; $display("FAIL %s_done t=%0d got=%b exp=%b", nm, t, done, ed); end
      checks++; if (busy !== eb) begin errors++; $display("FAIL %s_busy t=%0d got=%b exp=%b", nm, t, busy, eb); end
      checks++; if (dut.pin_oe !== eoe) begin errors++; $display("FAIL %s_oe t=%0d got=%b exp=%b", nm, t, dut.pin_oe, eoe); end
      checks++; if (pin !== ep) begin errors++; $display("FAIL %s_pin t=%0d got=%b exp=%b", nm, t, pin, ep); end
      if (t >= D + T + 1) begin
        checks++; if (sample_val !== (ext_en ? ext_v : 1'b1))
          begin errors++; $display("FAIL %s_sample t=%0d got=%b exp=%b", nm, t, sample_val, ext_en ? ext_v : 1'b1); end
      end
      if (t == 1) req[w] = 1'b0;
    end
    tb_oe = 1'b0;
  endtask

  // Both requesters held: each transaction is 9 cycles (3 drive, 4 turn, sample, idle).
  task automatic test_back_to_back();
    logic [NR-1:0] eg, ed;
    int j, ph;
    @(posedge clk); #1;
    req = 2'b11; req_val = 2'b10; req_dur = '0;
    req_dur[0 +: DW] = DW'(3); req_dur[DW +: DW] = DW'(3);
    for (int t = 1; t <= 37; t++) begin
      @(posedge clk); #2;
      j = (t - 1) / 9; ph = (t - 1) % 9;
      eg = (j < 4 && ph == 0) ? (NR'(1) << (j % 2)) : '0;
      ed = (j < 4 && ph == 7) ? (NR'(1) << (j % 2)) : '0;
      checks++; if (gnt !== eg) begin errors++; $display("FAIL b2b_gnt t=%0d got=%b exp=%b", t, gnt, eg); end
      checks++; if (done !== ed) begin errors++; $display("FAIL b2b_done t=%0d got=%b exp=%b", t, done, ed); end
      checks++; if (dut.pin_oe !== (j < 4 && ph < 3))
        begin errors++; $display("FAIL b2b_oe t=%0d got=%b exp=%b", t, dut.pin_oe, (j < 4 && ph < 3)); end
      if (j < 4 && ph < 3) begin
        checks++; if (pin !== req_val[j % 2]) begin errors++; $display("FAIL b2b_pin t=%0d got=%b exp=%b", t, pin, req_val[j % 2]); end
      end
      if (ed != '0) begin
        checks++; if (sample_val !== 1'b1) begin errors++; $display("FAIL b2b_sample t=%0d got=%b exp=1", t, sample_val); end
      end
      if (t == 28) req = '0;
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    req = 2'b01; req_val = 2'b00; req_dur = '0; req_dur[0 +: DW] = DW'(10);
    for (int t = 1; t <= 3; t++) begin
      @(posedge clk); #2;
      checks++; if (dut.pin_oe !== 1'b1 || pin !== 1'b0)
        begin errors++; $display("FAIL rm_drive t=%0d oe=%b pin=%b exp oe=1 pin=0", t, dut.pin_oe, pin); end
    end
    rst_n = 1'b0; #1;
    checks++; if (dut.pin_oe !== 1'b0 || pin !== 1'b1)
      begin errors++; $display("FAIL rm_release oe=%b pin=%b exp oe=0 pin=1", dut.pin_oe, pin); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy got=%b exp=0", busy); end
    req = '0;
    repeat (2) begin
      @(posedge clk); #2;
      checks++; if (done !== '0) begin errors++; $display("FAIL rm_nodone got=%b exp=00", done); end
    end
    rst_n = 1'b1; req = 2'b11; req_dur = '0;
    for (int t = 1; t <= 8; t++) begin
      @(posedge clk); #2;
      checks++; if (gnt !== ((t == 1) ? 2'b01 : 2'b00))
        begin errors++; $display("FAIL rm_gnt t=%0d got=%b exp=%b", t, gnt, (t == 1) ? 2'b01 : 2'b00); end
      checks++; if (done !== ((t == 6) ? 2'b01 : 2'b00))
        begin errors++; $display("FAIL rm_done t=%0d got=%b exp=%b", t, done, (t == 6) ? 2'b01 : 2'b00); end
      if (t == 1) req = '0;
    end
  endtask

  // Narrow-counter instance: full-scale duration must not wrap.
  task automatic test_max_dur();
    @(posedge clk); #1;
    r4_req = 2'b01; r4_val = 2'b00; r4_dur = '0; r4_dur[3:0] = 4'd15;
    for (int t = 1; t <= 22; t++) begin
      @(posedge clk); #2;
      checks++; if (dut4.pin_oe !== (t <= 15) || pin4 !== (t > 15))
        begin errors++; $display("FAIL max_pin t=%0d oe=%b pin=%b exp oe=%b", t, dut4.pin_oe, pin4, (t <= 15)); end
      checks++; if (r4_gnt !== ((t == 1) ? 2'b01 : 2'b00))
        begin errors++; $display("FAIL max_gnt t=%0d got=%b", t, r4_gnt); end
      checks++; if (r4_done !== ((t == 20) ? 2'b01 : 2'b00))
        begin errors++; $display("FAIL max_done t=%0d got=%b exp=%b", t, r4_done, (t == 20) ? 2'b01 : 2'b00); end
      checks++; if (r4_busy !== (t <= 20)) begin errors++; $display("FAIL max_busy t=%0d got=%b", t, r4_busy); end
      if (t == 1) r4_req = '0;
    end
  endtask

  // Random traffic vs. a transaction-window model: each grant at g owns
  // drive [g, g+d), turn [g+d, g+d+T), done at g+d+T, next arbitration after.
  task automatic test_random();
    logic [NR-1:0] pend, v, eg, ed;
    logic [DW-1:0] dr [NR];
    logic eoe, eb, es, ep, ext, ext_en, wv;
    int g, d, w, last, free_at;
    bit active;
    rst_n = 1'b0; req = '0; tb_oe = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    pend = '0; v = '0; active = 0; last = NR - 1; es = 1'b0; free_at = 0;
    g = 0; d = 1; w = 0; ext = 1'b1; ext_en = 1'b0; wv = 1'b0;
    for (int i = 0; i < NR; i++) dr[i] = '0;
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); #1;
      tb_oe = active && ext_en && (k >= g + d) && (k < g + d + T); tb_val = ext;
      #1;
      eg  = (active && k == g) ? (NR'(1) << w) : '0;
      ed  = (active && k == g + d + T) ? (NR'(1) << w) : '0;
      eoe = active && (k >= g) && (k < g + d);
      eb  = active && (k >= g) && (k <= g + d + T);
      ep  = eoe ? wv : (tb_oe ? ext : 1'b1);
      if (ed != '0) es = ext;
      checks++; if (gnt !== eg) begin errors++; $display("FAIL rnd_gnt k=%0d got=%b exp=%b", k, gnt, eg); end
      checks++; if (done !== ed) begin errors++; $display("FAIL rnd_done k=%0d got=%b exp=%b", k, done, ed); end
      checks++; if (busy !== eb) begin errors++; $display("FAIL rnd_busy k=%0d got=%b exp=%b", k, busy, eb); end
      checks++; if (dut.pin_oe !== eoe) begin errors++; $display("FAIL rnd_oe k=%0d got=%b exp=%b", k, dut.pin_oe, eoe); end
      checks++; if (pin !== ep) begin errors++; $display("FAIL rnd_pin k=%0d got=%b exp=%b", k, pin, ep); end
      checks++; if (sample_val !== es) begin errors++; $display("FAIL rnd_sample k=%0d got=%b exp=%b", k, sample_val, es); end
      if (active && k == g + d + T) begin active = 0; free_at = k + 1; end
      // Winner either drops its request or keeps it with fresh parameters.
      if (active && k == g) begin
        if ($urandom_range(1) == 1) pend[w] = 1'b0;
        else begin v[w] = 1'($urandom_range(1)); dr[w] = DW'($urandom_range(5)); end
      end
      for (int i = 0; i < NR; i++) begin
        if (!pend[i] && $urandom_range(3) == 0) begin
          pend[i] = 1'b1; v[i] = 1'($urandom_range(1)); dr[i] = DW'($urandom_range(5));
        end
      end
      req = pend; req_val = v;
      for (int i = 0; i < NR; i++) req_dur[i*DW +: DW] = dr[i];
      if (!active && k >= free_at && pend != '0) begin
        for (int j = NR; j >= 1; j--) if (pend[(last + j) % NR]) w = (last + j) % NR;
        g = k + 1; d = (dr[w] == '0) ? 1 : int'(dr[w]); wv = v[w];
        ext_en = 1'($urandom_range(1));
        ext = ext_en ? 1'($urandom_range(1)) : 1'b1;
        last = w; active = 1;
      end
    end
    req = '0; tb_oe = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single(0, 1'b1, 8, 1'b0, 1'b0, "drive1");
    test_single(1, 1'b0, 0, 1'b1, 1'b0, "dur0");
    test_back_to_back();
    test_reset_mid();
    test_max_dur();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
